button_debouncer: RTL



---
 rtl/button_pkg.sv | 15 +
 rtl/button_debouncer_if.sv | 22 ++
 rtl/debounce_channel.sv | 108 ++++++++++
 rtl/button_debouncer.sv | 37 +++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
// Defaults assume a 27 MHz system clock.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESSED,
    LONG_HELD
  } btn_state_t;

  // 10 ms debounce window and 1 s long-press threshold at 27 MHz
  localparam int DEBOUNCE_CYCLES_27M   = 270000;
  localparam int LONG_PRESS_CYCLES_27M = 27000000;

endpackage

// File: rtl/button_debouncer_if.sv
// Button pin bundle: raw active-low pins in, clean levels and event pulses out.
interface button_debouncer_if #(
  parameter int NUM_BTN = 2
);

  logic [NUM_BTN-1:0] btn_n;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_long;

  modport master (
    output btn_n,
    input  btn_level, btn_press, btn_release, btn_long
  );

  modport slave (
    input  btn_n,
    output btn_level, btn_press, btn_release, btn_long
  );

endinterface

// File: rtl/debounce_channel.sv
// One button: two-flop synchronizer, stability counter, hold counter and a
// three-state FSM producing a clean level plus press/release/long pulses.
module debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_27M,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_27M
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  logic          sync1, sync2;
  btn_state_t    state, state_d;
  logic [DW-1:0] deb_cnt, deb_cnt_d;
  logic [HW-1:0] hold_cnt, hold_cnt_d;
  logic          press_d, release_d, long_d;
  logic          s, level, differ, deb_fire;

  // Synchronizer resets to "released" so a held button reads as a fresh press.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  assign s        = ~sync2;
  assign level    = (state != RELEASED);
  assign differ   = (s != level);
  assign deb_fire = differ && (deb_cnt == DEB_LAST);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state;
    deb_cnt_d  = differ ? deb_cnt + DW'(1) : '0;
    hold_cnt_d = hold_cnt;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    unique case (state)
      RELEASED: begin
        if (deb_fire) begin
          state_d    = PRESSED;
          press_d    = 1'b1;
          deb_cnt_d  = '0;
          hold_cnt_d = '0;
        end
      end
      PRESSED: begin
        // An accepted release takes priority over a long press in the same cycle
        if (deb_fire) begin
          state_d   = RELEASED;
          release_d = 1'b1;
          deb_cnt_d = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt + HW'(1);
        end
      end
      LONG_HELD: begin
        if (deb_fire) begin
          state_d   = RELEASED;
          release_d = 1'b1;
          deb_cnt_d = '0;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RELEASED;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
    end else begin
      state       <= state_d;
      deb_cnt     <= deb_cnt_d;
      hold_cnt    <= hold_cnt_d;
      btn_level   <= (state_d != RELEASED);
      btn_press   <= press_d;
      btn_release <= release_d;
      btn_long    <= long_d;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounces NUM_BTN independent active-low push buttons into clean levels and
// single-cycle press, release and long-press events.
module button_debouncer
  import button_pkg::*;
#(
  parameter int NUM_BTN           = 2,
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_27M,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_27M
) (
  input  logic               clk,
  input  logic               reset,
  button_debouncer_if.slave  bus
);

  logic [NUM_BTN-1:0] level_v, press_v, release_v, long_v;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .btn_n      (bus.btn_n[i]),
      .btn_level  (level_v[i]),
      .btn_press  (press_v[i]),
      .btn_release(release_v[i]),
      .btn_long   (long_v[i])
    );
  end

  assign bus.btn_level   = level_v;
  assign bus.btn_press   = press_v;
  assign bus.btn_release = release_v;
  assign bus.btn_long    = long_v;

endmodule
